// File: rtl/dtc_pkg.sv
// Shared constants for the quarter-cycle pulse generator: FSM encodings,
// quarters per clk100 cycle and the tick-count width helper.
package dtc_pkg;

  localparam int QUARTERS = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  // One extra bit over the delay so that delay + width never wraps.
  function automatic int tick_w(input int delay_w);
    return delay_w + 1;
  endfunction

endpackage

// File: rtl/dtc_window_mask.sv
// Quarter-tick window mask: bit i is set when tick base+i lies inside [d, e).
module dtc_window_mask
  import dtc_pkg::*;
#(
  parameter int BW = 15
) (
  input  logic [BW-1:0]       base,
  input  logic [BW-1:0]       d,
  input  logic [BW-1:0]       e,
  output logic [QUARTERS-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < QUARTERS; i++) begin
      mask[i] = ((base + BW'(i)) >= d) && ((base + BW'(i)) < e);
    end
  end

endmodule

// File: rtl/dtc_pulse_gen.sv
// Digital-to-time converter: emits one pulse of programmed width at a programmed
// quarter-cycle delay after evt. Define DTC_REARM_EN for periodic re-arming.
module dtc_pulse_gen
  import dtc_pkg::*;
#(
  parameter int DELAY_W = 12,
  parameter int WIDTH_W = 8
) (
  input  logic               clk100,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DELAY_W-1:0] cmd_delay,
  input  logic [WIDTH_W-1:0] cmd_width,
  input  logic               evt,
  input  logic               abort,
  output logic [3:0]         ser_word,
  output logic               busy,
  output logic               done
);

  localparam int TW = tick_w(DELAY_W);
  localparam int BW = TW + 2;

  logic [1:0]          state;
  logic [DELAY_W-1:0]  d_q;
  logic [TW-1:0]       e_q;
  logic [TW-1:0]       n_q;
  logic [TW-1:0]       e_next;
  logic [BW-1:0]       base;
  logic                last_win;
  logic [QUARTERS-1:0] mask;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (&v) ? v : v + TW'(1);
  endfunction

  assign e_next    = TW'(cmd_delay) + TW'(cmd_width);
  assign base      = {n_q, 2'b00};
  assign last_win  = (base + BW'(QUARTERS)) >= BW'(e_q);
  assign cmd_ready = (state == S_IDLE);

  dtc_window_mask #(
    .BW (BW)
  ) u_mask (
    .base (base),
    .d    (BW'(d_q)),
    .e    (BW'(e_q)),
    .mask (mask)
  );

  // Window n mask is registered, so it appears one edge after it is computed.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      d_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      ser_word <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else if (abort) begin
      state    <= S_IDLE;
      n_q      <= '0;
      ser_word <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ser_word <= '0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            d_q   <= cmd_delay;
            e_q   <= e_next;
            state <= S_ARMED;
            busy  <= 1'b1;
          end
        end
        S_ARMED: begin
          if (evt) begin
            state <= S_RUN;
            n_q   <= '0;
          end
        end
        S_RUN: begin
          ser_word <= mask;
          if (last_win) begin
            done <= 1'b1;
`ifdef DTC_REARM_EN
            state <= S_ARMED;
`else
            state <= S_IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            n_q <= sat_inc(n_q);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
